// File: rtl/f_to_d_buf.sv
// Purpose : fetch-to-decode skid FIFO of {pc, inst} entries with branch flush.
// Latency : an entry pushed into an empty buffer is on D_* right after the push edge.
// Backpres: F_ready drops when full (registered); stall_D holds the head entry.
//
// Ports:
//   clk, rst          - single rising-edge clock, synchronous active-high reset
//   F_pc/F_inst/F_valid, F_ready  - fetch side offer / accept
//   stall_D, EX_taken - decode hold, taken-branch flush (flush beats push/pop)
//   D_pc/D_inst/D_valid, D_count  - head entry for decode, occupancy
//   flush_cnt         - saturating flush counter, present only with F_TO_D_BUF_STATS_EN
module f_to_d_buf #(
    parameter int               XLEN    = 32,
    parameter int               PC_BITS = 5,
    parameter int               DEPTH   = 4,
    parameter logic [XLEN-1:0]  NOP     = 'h2000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_BITS-1:0]         F_pc,
    input  logic [XLEN-1:0]            F_inst,
    input  logic                       F_valid,
    output logic                       F_ready,
    input  logic                       stall_D,
    input  logic                       EX_taken,
    output logic [PC_BITS-1:0]         D_pc,
    output logic [XLEN-1:0]            D_inst,
    output logic                       D_valid,
    output logic [$clog2(DEPTH):0]     D_count
`ifdef F_TO_D_BUF_STATS_EN
    ,
    output logic [15:0]                flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_BITS-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0]    inst_mem [DEPTH];
    logic [AW-1:0]      rptr;
    logic [AW-1:0]      wptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    // Ready and valid come straight from the count register so neither
    // side sees a combinational path from the other.
    assign F_ready = (count != FULL_CNT);
    assign D_valid = (count != '0);
    assign D_count = count;

    assign push = F_valid && F_ready && !EX_taken;
    assign pop  = D_valid && !stall_D && !EX_taken;

    // Head is read through the registered read pointer; an empty buffer
    // presents a bubble instead of stale storage.
    assign D_pc   = D_valid ? pc_mem[rptr]   : '0;
    assign D_inst = D_valid ? inst_mem[rptr] : NOP;

    // Storage carries no reset: only pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]   <= F_pc;
            inst_mem[wptr] <= F_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || EX_taken) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef F_TO_D_BUF_STATS_EN
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (EX_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_f_to_d_buf.sv
// Purpose : directed self-checking bench for f_to_d_buf (DEPTH=4 defaults).
// Latency : inputs driven 1 time unit after a rising edge, outputs checked there too.
// Backpres: exercises full-buffer refusal, stall hold, flush and reset priority.
module tb_f_to_d_buf;

    localparam logic [31:0] NOP_V = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  F_pc;
    logic [31:0] F_inst;
    logic        F_valid;
    logic        F_ready;
    logic        stall_D;
    logic        EX_taken;
    logic [4:0]  D_pc;
    logic [31:0] D_inst;
    logic        D_valid;
    logic [2:0]  D_count;
`ifdef F_TO_D_BUF_STATS_EN
    logic [15:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    f_to_d_buf dut (
        .clk      (clk),
        .rst      (rst),
        .F_pc     (F_pc),
        .F_inst   (F_inst),
        .F_valid  (F_valid),
        .F_ready  (F_ready),
        .stall_D  (stall_D),
        .EX_taken (EX_taken),
        .D_pc     (D_pc),
        .D_inst   (D_inst),
        .D_valid  (D_valid),
        .D_count  (D_count)
`ifdef F_TO_D_BUF_STATS_EN
        ,
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stalled(input logic [4:0] pc);
        stall_D = 1'b1;
        F_valid = 1'b1;
        F_pc    = pc;
        F_inst  = 32'h1000 + 32'(pc);
        tick();
        F_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; F_valid = 1'b0; F_pc = '0; F_inst = '0;
        stall_D = 1'b0; EX_taken = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (D_valid !== 1'b0) begin failures++; $display("FAIL reset_D_valid got %0h want 0", D_valid); end
        checks++; if (D_inst !== NOP_V) begin failures++; $display("FAIL reset_D_inst got %0h want %0h", D_inst, NOP_V); end
        checks++; if (D_pc !== 5'd0) begin failures++; $display("FAIL reset_D_pc got %0h want 0", D_pc); end
        checks++; if (F_ready !== 1'b1) begin failures++; $display("FAIL reset_F_ready got %0h want 1", F_ready); end
        checks++; if (D_count !== 3'd0) begin failures++; $display("FAIL reset_D_count got %0h want 0", D_count); end
    endtask

    task automatic test_fill_full();
        push_stalled(5'd1);
        checks++; if (D_valid !== 1'b1 || D_pc !== 5'd1) begin failures++; $display("FAIL first_push_latency got v=%0h pc=%0h want v=1 pc=1", D_valid, D_pc); end
        for (int i = 2; i <= 4; i++) push_stalled(5'(i));
        checks++; if (D_count !== 3'd4) begin failures++; $display("FAIL full_count got %0d want 4", D_count); end
        checks++; if (F_ready !== 1'b0) begin failures++; $display("FAIL full_F_ready got %0h want 0", F_ready); end
        push_stalled(5'd5);
        checks++; if (D_count !== 3'd4 || D_pc !== 5'd1) begin failures++; $display("FAIL full_refuse got cnt=%0d pc=%0h want cnt=4 pc=1", D_count, D_pc); end
        stall_D = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            checks++;
            if (D_valid !== 1'b1 || D_pc !== 5'(e) || D_inst !== 32'h1000 + 32'(e)) begin
                failures++;
                $display("FAIL drain_%0d got v=%0h pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", e, D_valid, D_pc, D_inst, e, 32'h1000 + 32'(e));
            end
            tick();
        end
        checks++; if (D_valid !== 1'b0 || D_pc !== 5'd0 || D_inst !== NOP_V) begin failures++; $display("FAIL drained_bubble got v=%0h pc=%0h inst=%0h want v=0 pc=0 inst=%0h", D_valid, D_pc, D_inst, NOP_V); end
    endtask

    task automatic test_back_to_back();
        stall_D = 1'b0;
        F_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            F_pc   = 5'(i);
            F_inst = 32'h2200 + 32'(i);
            tick();
            checks++;
            if (D_count !== 3'd1 || D_pc !== 5'(i) || D_inst !== 32'h2200 + 32'(i)) begin
                failures++;
                $display("FAIL stream_%0d got cnt=%0d pc=%0h inst=%0h want cnt=1 pc=%0h inst=%0h", i, D_count, D_pc, D_inst, i, 32'h2200 + 32'(i));
            end
        end
        F_valid = 1'b0;
        tick();
        checks++; if (D_valid !== 1'b0 || D_count !== 3'd0) begin failures++; $display("FAIL stream_end got v=%0h cnt=%0d want v=0 cnt=0", D_valid, D_count); end
    endtask

    task automatic test_flush();
        push_stalled(5'd10);
        push_stalled(5'd11);
        push_stalled(5'd12);
        EX_taken = 1'b1; F_valid = 1'b1; F_pc = 5'd7; F_inst = 32'h7777;
        tick();
        EX_taken = 1'b0; F_valid = 1'b0;
        checks++; if (D_count !== 3'd0 || D_valid !== 1'b0) begin failures++; $display("FAIL flush_count got cnt=%0d v=%0h want cnt=0 v=0", D_count, D_valid); end
        checks++; if (D_inst !== NOP_V || D_pc !== 5'd0) begin failures++; $display("FAIL flush_bubble got inst=%0h pc=%0h want inst=%0h pc=0", D_inst, D_pc, NOP_V); end
        checks++; if (F_ready !== 1'b1) begin failures++; $display("FAIL flush_F_ready got %0h want 1", F_ready); end
        push_stalled(5'd20);
        checks++; if (D_count !== 3'd1 || D_pc !== 5'd20) begin failures++; $display("FAIL after_flush_push got cnt=%0d pc=%0h want cnt=1 pc=14", D_count, D_pc); end
        stall_D = 1'b0;
        tick();
        checks++; if (D_count !== 3'd0) begin failures++; $display("FAIL after_flush_pop got cnt=%0d want 0", D_count); end
    endtask

    task automatic test_rst_mid();
        push_stalled(5'd3);
        push_stalled(5'd4);
        rst = 1'b1; EX_taken = 1'b1; F_valid = 1'b1; F_pc = 5'd9;
        tick();
        rst = 1'b0; EX_taken = 1'b0; F_valid = 1'b0; stall_D = 1'b0;
        checks++; if (D_valid !== 1'b0 || D_count !== 3'd0) begin failures++; $display("FAIL rst_mid_count got v=%0h cnt=%0d want v=0 cnt=0", D_valid, D_count); end
        checks++; if (D_inst !== NOP_V || D_pc !== 5'd0 || F_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_outputs got inst=%0h pc=%0h rdy=%0h want inst=%0h pc=0 rdy=1", D_inst, D_pc, F_ready, NOP_V); end
`ifdef F_TO_D_BUF_STATS_EN
        checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_flush_cnt got %0h want 0", flush_cnt); end
`endif
    endtask

`ifdef F_TO_D_BUF_STATS_EN
    task automatic test_stats();
        EX_taken = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        EX_taken = 1'b0;
        tick();
        checks++; if (flush_cnt !== 16'd3) begin failures++; $display("FAIL flush_cnt_3 got %0h want 3", flush_cnt); end
        EX_taken = 1'b1;
        for (int i = 0; i < 65532; i++) tick();
        EX_taken = 1'b0;
        checks++; if (flush_cnt !== 16'hFFFF) begin failures++; $display("FAIL flush_cnt_max got %0h want ffff", flush_cnt); end
        EX_taken = 1'b1;
        tick();
        EX_taken = 1'b0;
        checks++; if (flush_cnt !== 16'hFFFF) begin failures++; $display("FAIL flush_cnt_sat got %0h want ffff", flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_full();
        test_back_to_back();
        test_flush();
        test_rst_mid();
`ifdef F_TO_D_BUF_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f_to_d_buf.md
F_TO_D_BUF -- requirements
Module: f_to_d_buf

Interface
REQ-001 Parameters: XLEN, default 32, instruction width; PC_BITS, default 5, PC width; DEPTH, default 4, entry count (power of two, 2..16); NOP, default 32'h2000_0000, bubble instruction.
REQ-002 Ports: clk  in  1  rising-edge clock; the single clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 F_pc  in  PC_BITS  fetch PC; F_inst  in  XLEN  fetch instruction; F_valid  in  1  fetch offers an entry.
REQ-005 F_ready  out  1  buffer can accept an entry this cycle.
REQ-006 stall_D  in  1  decode holds its current entry; EX_taken  in  1  branch taken, flush.
REQ-007 D_pc  out  PC_BITS; D_inst  out  XLEN; D_valid  out  1  head entry for decode.
REQ-008 D_count  out  $clog2(DEPTH)+1  occupied entries.
REQ-009 Under F_TO_D_BUF_STATS_EN only: flush_cnt  out  16  flush event counter.

Function
REQ-010 Circular FIFO of DEPTH {pc, inst} entries, with read pointer, write pointer and count registers; pointers wrap modulo DEPTH.
REQ-011 F_ready = (D_count != DEPTH), decoded from registers only, with no combinational path from any input.
REQ-012 Push occurs when F_valid && F_ready && !EX_taken; the entry is written at the write pointer and the pointer advances at the clock edge.
REQ-013 Pop occurs when D_valid && !stall_D && !EX_taken; the read pointer advances at the clock edge.
REQ-014 D_valid = (D_count != 0); D_pc/D_inst drive the head entry when valid and 0/NOP when empty.
REQ-015 Latency: an entry pushed at edge N is presented on D_* immediately after edge N when the buffer was empty.
REQ-016 D_* outputs depend only on registered state, with no combinational path from F_* or stall_D.
REQ-017 Simultaneous push and pop: count unchanged, both pointers advance, and the head shows the next entry; this is legal at any non-full, non-empty occupancy.
REQ-018 Push and pop in the same cycle with an empty buffer is not possible, because pop requires D_valid.
REQ-019 Full: F_ready=0, and an F_valid offer is ignored (not written) while fetch holds the entry.
REQ-020 Empty: stall_D has no effect, and the outputs hold the 0/NOP bubble.
REQ-021 EX_taken has priority over push and pop: on that edge count=0 and rptr=wptr=0, and the next cycle shows D_valid=0, D_inst=NOP, D_pc=0 and F_ready=1.
REQ-022 FIFO storage contents need no reset or flush clearing; only pointers and count are state-significant.
REQ-023 Count never exceeds DEPTH and never underflows; no assertion is required, because this follows from REQ-011 and REQ-013.

Reset
REQ-024 On rst at a rising edge: count=0, rptr=0, wptr=0, and flush_cnt=0 when compiled in.
REQ-025 Outputs after reset: D_valid=0, D_inst=NOP, D_pc=0, F_ready=1, D_count=0.
REQ-026 rst has priority over EX_taken, push and pop.
REQ-027 rst asserted mid-stream discards all entries exactly as in REQ-024, with no partial drain.

Configuration
REQ-028 The macro F_TO_D_BUF_STATS_EN, when defined, adds the flush_cnt port and counter.
REQ-029 With the macro defined, flush_cnt increments on every edge with EX_taken=1 and rst=0, and saturates at 16'hFFFF.
REQ-030 Without the macro, there is no flush_cnt port or register, and all other behaviour is identical.

Verification
REQ-031 Reset, then idle -> D_valid=0, D_inst=32'h2000_0000, D_pc=0, F_ready=1, D_count=0.
REQ-032 Push pc=1..4 on consecutive cycles with stall_D=1 (DEPTH=4) -> D_count=4, F_ready=0; a 5th offer pc=5 is not written; release stall_D -> D_pc sequence 1,2,3,4, then D_valid=0.
REQ-033 Steady push/pop with stall_D=0, F_valid=1 for 10 cycles, pc=0..9 -> D_count stays 1 and D_pc lags F_pc by one cycle; pointers wrap with no loss.
REQ-034 Three entries buffered, then EX_taken=1 together with F_valid=1 (pc=7) -> next cycle D_count=0, D_inst=NOP; pc=7 is not stored.
REQ-035 rst asserted with 2 entries and EX_taken=1 in the same cycle -> reset state per REQ-025; with the macro defined, flush_cnt=0.
REQ-036 With F_TO_D_BUF_STATS_EN defined: 3 flush pulses -> flush_cnt=3; forced to 16'hFFFF, then one more flush -> remains 16'hFFFF.
